// File: rtl/salu_instr_pkg.sv
// Shared types for the SALU issue path.
//   salu_instr_params_t : decoded scalar op (two SGPR sources, one SGPR
//                         destination with write flag, common fields)
//   sgpr_sb_t           : one pending-write bit per tracked SGPR
package salu_instr_pkg;

    localparam int SALU_NUM_REQ    = 4;
    localparam int SALU_SGPR_COUNT = 106;
    localparam int SGPR_ADDR_W     = 8;

    typedef enum logic {
        sgpr_nop   = 1'b0,
        sgpr_write = 1'b1
    } sgpr_op_e;

    typedef struct packed {
        logic [1:0][SGPR_ADDR_W-1:0] addr;
    } salu_rd_req_t;

    typedef struct packed {
        logic [0:0][SGPR_ADDR_W-1:0] addr;
        sgpr_op_e                    sgpr_op;
    } salu_wr_req_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] imm;
    } salu_common_t;

    typedef struct packed {
        salu_rd_req_t rd_req;
        salu_wr_req_t wr_req;
        salu_common_t common_params;
    } salu_instr_params_t;

    typedef logic [SALU_SGPR_COUNT-1:0] sgpr_sb_t;

endpackage

// File: rtl/salu_issue_arbiter_rr.sv
// Round-robin picker: first set bit of elig_i at or after ptr_i, wrapping.
//   elig_i    : eligible requester mask
//   ptr_i     : highest-priority requester index
//   gnt_o     : one-hot grant (zero when nothing is eligible)
//   gnt_idx_o : index of the granted requester (0 when no grant)
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] elig_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o
);

    logic found;

    // Two passes: upper segment [ptr..N-1] first, then wrap from 0.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && elig_i[j] && (j >= int'(ptr_i))) begin
                found     = 1'b1;
                gnt_o[j]  = 1'b1;
                gnt_idx_o = IDX_W'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && elig_i[j]) begin
                found     = 1'b1;
                gnt_o[j]  = 1'b1;
                gnt_idx_o = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/salu_issue_arbiter.sv
// Arbitrates NUM_REQ decoded scalar-op streams onto one SALU issue slot,
// holding back any op that touches an SGPR with a write still in flight.
//   clk, rst            : clock, async active-high reset
//   req_valid/req_data  : per-requester decoded op
//   req_ready           : one-hot-or-zero grant (transfer = valid & ready)
//   issue_valid/_data/_id : registered op presented to the SALU
//   issue_ready         : SALU accepts the presented op
//   wb_valid/wb_addr    : SGPR writeback retiring a pending write
module salu_issue_arbiter
    import salu_instr_pkg::*;
#(
    parameter int NUM_REQ    = SALU_NUM_REQ,
    parameter int SGPR_COUNT = SALU_SGPR_COUNT,
    parameter int ADDR_W     = SGPR_ADDR_W,
    parameter int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  salu_instr_params_t [NUM_REQ-1:0]      req_data,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic                                  issue_valid,
    output salu_instr_params_t                    issue_data,
    output logic [IDX_W-1:0]                      issue_id,
    input  logic                                  issue_ready,
    input  logic                                  wb_valid,
    input  logic [ADDR_W-1:0]                     wb_addr
);

    logic                      issue_valid_q, issue_valid_d;
    salu_instr_params_t        issue_data_q,  issue_data_d;
    logic [IDX_W-1:0]          issue_id_q,    issue_id_d;
    logic [IDX_W-1:0]          rr_ptr_q,      rr_ptr_d;
    logic [SGPR_COUNT-1:0]     sb_q,          sb_d;

    logic [NUM_REQ-1:0]        elig;
    logic [NUM_REQ-1:0]        gnt;
    logic [IDX_W-1:0]          gnt_idx;
    logic                      slot_free;
    logic                      any_gnt;
    salu_instr_params_t        gnt_data;
    logic                      set_en;
    logic [ADDR_W-1:0]         set_addr;

    // Encodings >= SGPR_COUNT never match a scoreboard bit, so untracked
    // addresses fall out of the compare loop naturally.
    function automatic logic sb_hit(input logic [ADDR_W-1:0] a,
                                    input logic [SGPR_COUNT-1:0] sb);
        sb_hit = 1'b0;
        for (int k = 0; k < SGPR_COUNT; k++)
            if ((32'(a) == k) && sb[k]) sb_hit = 1'b1;
    endfunction

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid[i]
                && !sb_hit(ADDR_W'(req_data[i].rd_req.addr[0]), sb_q)
                && !sb_hit(ADDR_W'(req_data[i].rd_req.addr[1]), sb_q)
                && !((req_data[i].wr_req.sgpr_op == sgpr_write)
                     && sb_hit(ADDR_W'(req_data[i].wr_req.addr[0]), sb_q));
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .elig_i    (elig),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign slot_free = !issue_valid_q || issue_ready;
    // rst gate keeps req_ready low while in reset even with valid inputs.
    assign req_ready = (slot_free && !rst) ? gnt : '0;
    assign any_gnt   = |req_ready;
    assign gnt_data  = req_data[gnt_idx];
    assign set_en    = any_gnt && (gnt_data.wr_req.sgpr_op == sgpr_write);
    assign set_addr  = ADDR_W'(gnt_data.wr_req.addr[0]);

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_data_d  = issue_data_q;
        issue_id_d    = issue_id_q;
        rr_ptr_d      = rr_ptr_q;
        if (any_gnt) begin
            issue_valid_d = 1'b1;
            issue_data_d  = gnt_data;
            issue_id_d    = gnt_idx;
            rr_ptr_d      = (int'(gnt_idx) == NUM_REQ-1) ? '0 : gnt_idx + IDX_W'(1);
        end else if (issue_ready) begin
            issue_valid_d = 1'b0;
        end
    end

    // Set dominates clear so a new writer is not lost to an older writeback.
    always_comb begin
        sb_d = sb_q;
        for (int k = 0; k < SGPR_COUNT; k++) begin
            if (wb_valid && (32'(wb_addr) == k)) sb_d[k] = 1'b0;
            if (set_en && (32'(set_addr) == k))  sb_d[k] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid_q <= 1'b0;
            issue_data_q  <= '0;
            issue_id_q    <= '0;
            rr_ptr_q      <= '0;
            sb_q          <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_data_q  <= issue_data_d;
            issue_id_q    <= issue_id_d;
            rr_ptr_q      <= rr_ptr_d;
            sb_q          <= sb_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_data  = issue_data_q;
    assign issue_id    = issue_id_q;

endmodule
